// File: rtl/cache_fill_fsm.sv
// ---------------------------------------------------------------------------
// cache_fill_fsm
//
// Purpose:
//   Miss-handling engine sitting between the cache arrays and a pipelined,
//   multi-cycle main memory. On a miss it requests every word of the block
//   that holds the missed address, one request per cycle, streams the
//   returned words into the data array in request order, then writes the
//   tag. The CPU is held stalled through fsm_busy until the block is
//   installed, plus one settling cycle (DONE) so that a miss_detected still
//   high from the old lookup cannot start a second fill.
//
// Ports:
//   clk, rst             clock and synchronous active-high reset
//   miss_detected        cache lookup missed this cycle
//   miss_address         byte address of the missing access
//   fsm_busy             stall request to the CPU
//   memory_read          one-word read request to main memory
//   memory_address       byte address of the current request
//   memory_data_valid    memory_data carries a returned word
//   memory_data          returned word, in request order
//   write_data_array     write cache_data at cache_word_index
//   cache_word_index     word offset within the block being written
//   cache_data           word to write (memory_data passed through)
//   write_tag_array      write tag/valid for the block being filled
//   fill_done            one-cycle pulse, block installed
// ---------------------------------------------------------------------------
module cache_fill_fsm #(
    parameter int BLOCK_WORDS = 8,
    parameter int MEM_LATENCY = 4,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           miss_detected,
    input  logic [ADDR_W-1:0]              miss_address,
    output logic                           fsm_busy,
    output logic                           memory_read,
    output logic [ADDR_W-1:0]              memory_address,
    input  logic                           memory_data_valid,
    input  logic [DATA_W-1:0]              memory_data,
    output logic                           write_data_array,
    output logic [$clog2(BLOCK_WORDS)-1:0] cache_word_index,
    output logic [DATA_W-1:0]              cache_data,
    output logic                           write_tag_array,
    output logic                           fill_done
);

    localparam int IDX_W = $clog2(BLOCK_WORDS);
    localparam int CNT_W = IDX_W + 1;

    localparam logic [CNT_W-1:0]  BLOCK_CNT  = CNT_W'(BLOCK_WORDS);
    localparam logic [CNT_W-1:0]  LAST_CNT   = CNT_W'(BLOCK_WORDS - 1);
    localparam logic [ADDR_W-1:0] BLOCK_MASK = ADDR_W'(2 * BLOCK_WORDS - 1);

    // The word index is carved straight out of the counters, so the block
    // size has to be a power of two. The memory latency only has to be
    // positive: responses are consumed whenever they arrive.
    if ((BLOCK_WORDS < 2) || ((BLOCK_WORDS & (BLOCK_WORDS - 1)) != 0)) begin : gBadBlockWords
        $error("cache_fill_fsm: BLOCK_WORDS must be a power of two >= 2");
    end
    if (MEM_LATENCY < 1) begin : gBadLatency
        $error("cache_fill_fsm: MEM_LATENCY must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } fillState_t;

    fillState_t        state;
    logic [ADDR_W-1:0] base;
    logic [CNT_W-1:0]  reqCnt;
    logic [CNT_W-1:0]  rcvCnt;

    logic reqActive;
    logic wordWrite;
    logic lastWrite;

    // Request and write qualifiers shared by the state register and the
    // output decode. The counters saturate at BLOCK_WORDS, which is what
    // stops requests and drops any response beyond the eighth.
    assign reqActive = (state == FILL) && (reqCnt < BLOCK_CNT);
    assign wordWrite = (state == FILL) && memory_data_valid && (rcvCnt < BLOCK_CNT);
    assign lastWrite = wordWrite && (rcvCnt == LAST_CNT);

    // State register. The missed address is latched block-aligned on entry
    // to FILL, so later miss_address changes cannot redirect the fill. The
    // fill ends on the last data write; DONE always lasts exactly one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            base   <= '0;
            reqCnt <= '0;
            rcvCnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (miss_detected) begin
                        base   <= miss_address & ~BLOCK_MASK;
                        reqCnt <= '0;
                        rcvCnt <= '0;
                        state  <= FILL;
                    end
                end
                FILL: begin
                    if (reqActive) begin
                        reqCnt <= reqCnt + CNT_W'(1);
                    end
                    if (wordWrite) begin
                        rcvCnt <= rcvCnt + CNT_W'(1);
                    end
                    if (lastWrite) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Output decode. Everything is quiet while rst is high, so neither a
    // request nor a tag write can escape in the cycle the fill is aborted.
    // Request addresses wrap inside the block because only the low index
    // bits of reqCnt are added to the aligned base.
    always_comb begin
        fsm_busy         = 1'b0;
        memory_read      = 1'b0;
        memory_address   = '0;
        write_data_array = 1'b0;
        cache_word_index = '0;
        cache_data       = memory_data;
        write_tag_array  = 1'b0;
        fill_done        = 1'b0;
        if (!rst) begin
            unique case (state)
                IDLE: begin
                    fsm_busy = miss_detected;
                end
                FILL: begin
                    fsm_busy         = 1'b1;
                    memory_read      = reqActive;
                    memory_address   = base + ADDR_W'({reqCnt[IDX_W-1:0], 1'b0});
                    write_data_array = wordWrite;
                    cache_word_index = rcvCnt[IDX_W-1:0];
                    write_tag_array  = lastWrite;
                    fill_done        = lastWrite;
                end
                DONE: begin
                    fsm_busy = 1'b1;
                end
                default: begin
                    fsm_busy = 1'b0;
                end
            endcase
        end
    end

endmodule
